uart_sdram_burst_bridge: RTL
============================

Name: uart_sdram_burst_bridge

Overview:
- Byte-stream command parser between the UART receiver/transmitter and the SDRAM controller user port.
- Generalises the single-word R/W bridge: parametrised address/data byte counts, burst length with address auto-increment, read data returned over a TX byte stream, write completion reply, and an inter-byte timeout that aborts partial frames.

Parameters:
BYTE_W, 8, UART byte width
ADR_BYTES, 3, address bytes per frame; ADR_W = BYTE_W*ADR_BYTES
DATA_BYTES, 2, bytes per SDRAM word; DATA_W = BYTE_W*DATA_BYTES
TIMEOUT_CYC, 1000000, idle cycles allowed between RX bytes inside a frame (>=2)

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
rx_data  in  BYTE_W  received byte
rx_stb  in  1  rx_data valid
rx_ack  out  1  byte accepted (transfer = rx_stb & rx_ack)
tx_data  out  BYTE_W  byte to transmit
tx_stb  out  1  tx_data valid, held until tx_ack
tx_ack  in  1  transmitter took byte
sd_adr  out  ADR_W  SDRAM word address
sd_wdata  out  DATA_W  write data
sd_rdata  in  DATA_W  read data, valid in sd_ack cycle of a read
sd_stb_rd  out  1  read request
sd_stb_wt  out  1  write request
sd_ack  in  1  request completed
busy  out  1  high whenever state != IDLE
err_timeout  out  1  one-cycle pulse on frame abort

Behaviour:
- Reset (RST_N low, any time, async): state IDLE; all outputs 0; counters, sd_adr, sd_wdata, tx_data cleared. Mid-operation reset drops the frame; no further strobes.
- Frame: cmd byte, ADR_BYTES address bytes MSB first, one length byte N (words; 0 means 256), then for writes N*DATA_BYTES data bytes MSB first per word.
- Cmd 0x52 'R' = read, 0x57 'W' = write; any other byte in IDLE is consumed (rx_ack=1) and ignored.
- rx_ack = rx_stb in IDLE, ADR, LEN, WDATA; 0 in all other states (backpressure).
- States: IDLE -> ADR (byte index 0..ADR_BYTES-1) -> LEN -> read: RREQ -> RSEND -> RREQ.. ; write: WDATA -> WREQ -> WDATA.. -> WACK -> IDLE.
- RREQ: sd_stb_rd=1 with sd_adr stable until sd_ack; on sd_ack capture sd_rdata, go RSEND. RSEND: emit DATA_BYTES bytes MSB first, tx_stb held, tx_data stable until tx_ack; next byte presented the cycle after tx_ack. After last byte: remaining words>0 -> RREQ with sd_adr+1, else IDLE.
- WDATA: after DATA_BYTES bytes, WREQ: sd_stb_wt=1 until sd_ack, sd_adr/sd_wdata stable. On sd_ack: remaining>0 -> WDATA with sd_adr+1, else WACK.
- WACK: tx byte 0x4B 'K' until tx_ack -> IDLE.
- Strobes drop the cycle after the ack cycle; never both sd strobes high.
- sd_adr increments modulo 2^ADR_W (0xFFFFFF+1 = 0x000000 at default).
- Word counter 9 bits; N=0 loads 256.
- Timeout: counter runs only in ADR, LEN, WDATA, cleared on each accepted byte and on entry. Reaching TIMEOUT_CYC consecutive cycles without a byte -> IDLE, err_timeout pulses 1 cycle, no SDRAM request for the partial word; already written words of the burst remain written. Byte arriving in the same cycle as expiry is accepted and timeout is suppressed.
- sd_ack outside RREQ/WREQ ignored; tx_ack outside RSEND/WACK ignored.
- busy combinational from state.

Test Plan:
- Write: 57 00 01 00 01 12 34 -> one sd_stb_wt with sd_adr=0x000100, sd_wdata=0x1234; after sd_ack, tx 0x4B; busy low after tx_ack.
- Read burst wrap: 52 FF FF FF 02, sd_rdata 0xABCD then 0x0102 -> reads at 0xFFFFFF then 0x000000; tx bytes AB CD 01 02 in order.
- Backpressure: tx_ack delayed 5 cycles per byte -> tx_data stable, tx_stb high throughout, rx_ack=0 during RSEND.
- Timeout: TIMEOUT_CYC=16, send 57 00 00 then stall 16 cycles -> err_timeout single pulse, IDLE, no sd strobe; next 41 byte ignored.
- Length 0: 52 00 00 00 00 -> 256 read requests, addresses 0x000000..0x0000FF, 512 tx bytes.
- Reset mid-burst: RST_N low while sd_stb_wt high -> all outputs 0 immediately; after release, fresh frame works.

Source files
------------

// File: rtl/uart_sdram_burst_bridge.sv
// rtl/uart_sdram_burst_bridge.sv - UART byte-stream command parser driving an SDRAM user port
// Handles 'R'/'W' burst frames with address auto-increment, TX read-back, 'K' write reply and inter-byte timeout.
module uart_sdram_burst_bridge #(
  parameter int BYTE_W      = 8,
  parameter int ADR_BYTES   = 3,
  parameter int DATA_BYTES  = 2,
  parameter int TIMEOUT_CYC = 1000000,
  localparam int ADR_W  = BYTE_W * ADR_BYTES,
  localparam int DATA_W = BYTE_W * DATA_BYTES
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_stb,
  output logic              rx_ack,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_stb,
  input  logic              tx_ack,
  output logic [ADR_W-1:0]  sd_adr,
  output logic [DATA_W-1:0] sd_wdata,
  input  logic [DATA_W-1:0] sd_rdata,
  output logic              sd_stb_rd,
  output logic              sd_stb_wt,
  input  logic              sd_ack,
  output logic              busy,
  output logic              err_timeout
);

  localparam int IDX_MAX = (ADR_BYTES > DATA_BYTES) ? ADR_BYTES : DATA_BYTES;
  localparam int IW      = $clog2(IDX_MAX + 1);
  localparam int TW      = $clog2(TIMEOUT_CYC + 1);
  localparam int WCW     = BYTE_W + 1;

  localparam logic [BYTE_W-1:0] CMD_R   = BYTE_W'(8'h52);
  localparam logic [BYTE_W-1:0] CMD_W   = BYTE_W'(8'h57);
  localparam logic [BYTE_W-1:0] REPLY_K = BYTE_W'(8'h4B);
  localparam logic [TW-1:0]     T_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0]     ADR_LAST  = IW'(ADR_BYTES - 1);
  localparam logic [IW-1:0]     DATA_LAST = IW'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADR, S_LEN, S_RREQ, S_RSEND, S_WDATA, S_WREQ, S_WACK
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [WCW-1:0]    words_q, words_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [TW-1:0]     tout_q, tout_d;
  logic              is_wr_q, is_wr_d;
  logic              err_q, err_d;
  logic              timed_st;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      words_q <= '0;
      adr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      tout_q  <= '0;
      is_wr_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      words_q <= words_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      tout_q  <= tout_d;
      is_wr_q <= is_wr_d;
      err_q   <= err_d;
    end
  end

  assign timed_st    = (state_q == S_ADR) || (state_q == S_LEN) || (state_q == S_WDATA);
  assign rx_ack      = rx_stb && (timed_st || (state_q == S_IDLE));
  assign busy        = (state_q != S_IDLE);
  assign sd_stb_rd   = (state_q == S_RREQ);
  assign sd_stb_wt   = (state_q == S_WREQ);
  assign tx_stb      = (state_q == S_RSEND) || (state_q == S_WACK);
  assign sd_adr      = adr_q;
  assign sd_wdata    = wdata_q;
  assign err_timeout = err_q;
  // The outgoing byte is always the top byte of rdata_q, which doubles as the TX shift register.
  assign tx_data     = rdata_q[DATA_W-1 -: BYTE_W];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    words_d = words_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    is_wr_d = is_wr_q;
    tout_d  = '0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_ack && (rx_data == CMD_R || rx_data == CMD_W)) begin
          is_wr_d = (rx_data == CMD_W);
          idx_d   = '0;
          state_d = S_ADR;
        end
      end
      S_ADR: begin
        if (rx_ack) begin
          adr_d = (adr_q << BYTE_W) | ADR_W'(rx_data);
          if (idx_q == ADR_LAST) begin
            idx_d   = '0;
            state_d = S_LEN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_LEN: begin
        if (rx_ack) begin
          words_d = (rx_data == '0) ? WCW'(1 << BYTE_W) : WCW'(rx_data);
          state_d = is_wr_q ? S_WDATA : S_RREQ;
        end
      end
      S_RREQ: begin
        if (sd_ack) begin
          rdata_d = sd_rdata;
          idx_d   = '0;
          state_d = S_RSEND;
        end
      end
      S_RSEND: begin
        if (tx_ack) begin
          rdata_d = rdata_q << BYTE_W;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            words_d = words_q - 1'b1;
            if (words_q == WCW'(1)) begin
              state_d = S_IDLE;
            end else begin
              adr_d   = adr_q + 1'b1;
              state_d = S_RREQ;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_WDATA: begin
        if (rx_ack) begin
          wdata_d = (wdata_q << BYTE_W) | DATA_W'(rx_data);
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = S_WREQ;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_WREQ: begin
        if (sd_ack) begin
          words_d = words_q - 1'b1;
          if (words_q == WCW'(1)) begin
            rdata_d = DATA_W'(REPLY_K) << (DATA_W - BYTE_W);
            state_d = S_WACK;
          end else begin
            adr_d   = adr_q + 1'b1;
            state_d = S_WDATA;
          end
        end
      end
      S_WACK: begin
        if (tx_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A byte in the expiry cycle wins; the partial frame is dropped only on a silent cycle.
    if (timed_st && !rx_ack) begin
      if (tout_q == T_LAST) begin
        state_d = S_IDLE;
        idx_d   = '0;
        err_d   = 1'b1;
      end else begin
        tout_d = tout_q + 1'b1;
      end
    end
  end

endmodule
